relu_maxpool_22_layer1: RTL and testbench
=========================================

Name: relu_maxpool_22_layer1

Overview:
Post-processing stage directly downstream of the layer-1 5x5 convolution. It consumes the serial, raster-ordered conv result stream (24x24 per output channel) and adds a per-channel bias, then applies ReLU and requantises with shift and saturate to an unsigned feature width. It then performs 2x2 stride-2 max pooling with a half-row line buffer and emits a 12x12 pooled map per channel, ready to feed the layer-2 convolution.

Parameters:
I_BW, 20, width of signed conv result input
B_BW, 16, width of signed bias (same fixed-point scale as conv accumulator)
O_BW, 8, width of unsigned pooled output
I_SIZE, 24, conv output map width/height; must be even
Q_SHIFT, 4, arithmetic right shift applied after bias+ReLU

Ports:
clk  input  1  clock
global_rst_n  input  1  asynchronous active-low reset
rst  input  1  synchronous clear
self_rst  input  1  synchronous clear at channel boundary
user_reset  input  1  synchronous clear from software
i_data  input  I_BW  signed conv result
i_valid  input  1  i_data qualifier, one pixel per asserted cycle
i_bias  input  B_BW  signed bias for current channel, stable during frame
o_data  output  O_BW  unsigned pooled pixel
o_valid  output  1  o_data qualifier, single-cycle per pixel
o_end  output  1  frame done, level

Behaviour:
- Reset: global_rst_n low (async) or any of rst/self_rst/user_reset high at a clock edge (sync clear). Either clears all counters, the pipeline valids, o_data=0, o_valid=0 and o_end=0. Line-buffer contents are not cleared; every entry is written before it is read.
- Stage 1 (registered, on i_valid): sum = sext(i_data)+sext(i_bias) at I_BW+1 bits. If sum<0 the result is 0. Otherwise q = sum>>Q_SHIFT, and q saturates to 2^O_BW-1. The stage-1 valid bit follows i_valid.
- Position counters col, row (0..I_SIZE-1) advance on each stage-1 valid. col wraps to 0 and row increments at col=I_SIZE-1.
- Stage 2 (on stage-1 valid):
  - col even: hold <= q.
  - col odd: h = max(hold,q).
  - row even and col odd: buf[col>>1] <= h.
  - row odd and col odd: o_data <= max(buf[col>>1],h), o_valid <= 1.
  - o_valid is 0 in every other cycle.
- Latency: o_valid rises exactly 2 cycles after the i_valid cycle carrying the bottom-right pixel of each 2x2 window.
- Gaps in i_valid are allowed at any point. Nothing advances while i_valid=0, and the output ordering and values are unaffected.
- Line buffer: I_SIZE/2 entries x O_BW. It needs a single write port and a single read port. A read and a write never hit the same entry in one cycle.
- Frame end: after the pixel at row=I_SIZE-1, col=I_SIZE-1 produces its output, o_end goes high the next cycle. o_end stays high until a sync clear or global reset.
- While o_end=1, further i_valid pulses are ignored. The counters do not wrap into a new frame.
- Clear mid-frame: all partial state is discarded. The next i_valid pixel is treated as row 0, col 0, and no stale output is emitted.
- Simultaneous sync clear and i_valid: the clear wins and the pixel is dropped.
- Output count per frame is exactly (I_SIZE/2)^2 = 144 at default.
- Comparisons are unsigned on O_BW values, because all post-ReLU values are at least 0.

Test Plan:
- Constant i_data=100, bias=0, Q_SHIFT=0, continuous valid for 576 cycles. Required: 144 o_valid pulses, all o_data=100. The first pulse comes 2 cycles after input index 25 (row1,col1). o_end rises 1 cycle after the 144th pulse.
- i_data=-50, bias=20, Q_SHIFT=0. Required: all outputs 0. Repeat with i_data=5000, Q_SHIFT=4: 5000>>4=312, so every output saturates to 255.
- Per window, put value 77 in one of the 4 positions (rotating TL/TR/BL/BR) and 3 elsewhere, Q_SHIFT=0. Required: every output is 77, in raster order.
- Same data as the first scenario with i_valid toggling 1/0 randomly. Required: identical 144-value output sequence, and each pulse comes 2 cycles after its BR input.
- Assert user_reset at input 300, then restart a fresh 576-pixel frame of value 9. Required: no output between the clear and the new frame's row1,col1. Then 144 outputs of 9 and o_end; o_end is 0 right after the clear.
- Pulse global_rst_n low asynchronously mid-cycle during the frame. Required: o_valid, o_end and o_data are 0 immediately. Extra i_valid after o_end produces no output.

Source files
------------

// File: rtl/relu_maxpool_22_layer1.sv
// Layer-1 post-processing: per-channel bias, ReLU, shift/saturate requantise,
// then 2x2 stride-2 max pooling over a raster-ordered I_SIZE x I_SIZE stream.
module relu_maxpool_22_layer1 #(
    parameter int I_BW    = 20,
    parameter int B_BW    = 16,
    parameter int O_BW    = 8,
    parameter int I_SIZE  = 24,
    parameter int Q_SHIFT = 4
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              rst,
    input  logic              self_rst,
    input  logic              user_reset,
    input  logic [I_BW-1:0]   i_data,
    input  logic              i_valid,
    input  logic [B_BW-1:0]   i_bias,
    output logic [O_BW-1:0]   o_data,
    output logic              o_valid,
    output logic              o_end
);

    localparam int CW   = $clog2(I_SIZE);
    localparam int HALF = I_SIZE / 2;
    localparam int SW   = I_BW + 1;
    localparam logic [CW-1:0]   LAST = CW'(I_SIZE - 1);
    localparam logic [O_BW-1:0] QMAX = '1;

    logic            sync_clr;
    logic signed [SW-1:0] sum;
    logic [SW-1:0]   shifted;
    logic [O_BW-1:0] q_next;

    logic            s1_valid;
    logic [O_BW-1:0] s1_q;
    logic [CW-1:0]   col;
    logic [CW-1:0]   row;
    logic [O_BW-1:0] hold;
    logic            frame_done;

    logic [O_BW-1:0] line_buf [HALF];
    logic [O_BW-1:0] h;
    logic [O_BW-1:0] buf_rd;
    logic [O_BW-1:0] pooled;
    logic            s2_go;

    assign sync_clr = rst | self_rst | user_reset;
    // Pixels arriving once the frame has completed are dropped at both stages.
    assign s2_go    = s1_valid & ~frame_done;

    always_comb begin
        sum     = SW'($signed(i_data)) + SW'($signed(i_bias));
        shifted = '0;
        q_next  = '0;
        if (!sum[SW-1]) begin
            shifted = $unsigned(sum) >> Q_SHIFT;
            if (|shifted[SW-1:O_BW]) begin
                q_next = QMAX;
            end else begin
                q_next = shifted[O_BW-1:0];
            end
        end
    end

    always_comb begin
        h      = (hold > s1_q) ? hold : s1_q;
        buf_rd = line_buf[col[CW-1:1]];
        pooled = (buf_rd > h) ? buf_rd : h;
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            s1_valid   <= 1'b0;
            s1_q       <= '0;
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            frame_done <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_end      <= 1'b0;
        end else if (sync_clr) begin
            s1_valid   <= 1'b0;
            s1_q       <= '0;
            col        <= '0;
            row        <= '0;
            hold       <= '0;
            frame_done <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_end      <= 1'b0;
        end else begin
            s1_valid <= i_valid & ~frame_done;
            if (i_valid && !frame_done) begin
                s1_q <= q_next;
            end
            o_valid <= 1'b0;
            o_end   <= frame_done;
            if (s2_go) begin
                if (!col[0]) begin
                    hold <= s1_q;
                end
                if (col[0] && row[0]) begin
                    o_data  <= pooled;
                    o_valid <= 1'b1;
                end
                // The counters park on the last pixel instead of wrapping.
                if (col == LAST) begin
                    if (row == LAST) begin
                        frame_done <= 1'b1;
                    end else begin
                        col <= '0;
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Even rows store the horizontal max; odd rows read it back at the same column.
    always_ff @(posedge clk) begin
        if (s2_go && !sync_clr && col[0] && !row[0]) begin
            line_buf[col[CW-1:1]] <= h;
        end
    end

endmodule

// File: tb/tb_relu_maxpool_22_layer1.sv
// Directed bench for relu_maxpool_22_layer1: frame patterns with hand-derived
// pooled values, output timing, frame-end, clears and async reset.
module tb_relu_maxpool_22_layer1;

    localparam int I_BW = 20;
    localparam int B_BW = 16;
    localparam int O_BW = 8;
    localparam int I_SIZE = 24;
    localparam int Q_SHIFT = 4;
    localparam int NPIX = I_SIZE * I_SIZE;

    logic clk = 1'b0;
    logic global_rst_n = 1'b0;
    logic rst = 1'b0;
    logic self_rst = 1'b0;
    logic user_reset = 1'b0;
    logic [I_BW-1:0] i_data = '0;
    logic i_valid = 1'b0;
    logic [B_BW-1:0] i_bias = '0;
    logic [O_BW-1:0] o_data;
    logic o_valid;
    logic o_end;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_out_t = 0;
    bit end_seen = 1'b0;
    int end_cyc = 0;

    logic [O_BW-1:0] exp_q[$];
    int exp_t_q[$];
    logic [O_BW-1:0] got_q[$];
    int got_t_q[$];

    relu_maxpool_22_layer1 #(
        .I_BW(I_BW), .B_BW(B_BW), .O_BW(O_BW), .I_SIZE(I_SIZE), .Q_SHIFT(Q_SHIFT)
    ) dut (
        .clk(clk),
        .global_rst_n(global_rst_n),
        .rst(rst),
        .self_rst(self_rst),
        .user_reset(user_reset),
        .i_data(i_data),
        .i_valid(i_valid),
        .i_bias(i_bias),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_end(o_end)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // output monitor
    always @(negedge clk) begin
        if (o_valid) begin
            got_q.push_back(o_data);
            got_t_q.push_back(cyc);
        end
        if (o_end && !end_seen) begin
            end_seen = 1'b1;
            end_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q6(input int w, input int p);
        return (w * 37 + p * 61 + 11) % 256;
    endfunction

    function automatic int raw_val(input int pat, input int r, input int c);
        int w, p;
        w = (r / 2) * (I_SIZE / 2) + (c / 2);
        p = (r % 2) * 2 + (c % 2);
        case (pat)
            0: return 1600 + (c % 16);
            1: return -50;
            2: return 5000;
            3: return -100;
            4: return (p == w % 4) ? 77 * 16 : 3 * 16;
            5: return 9 * 16;
            default: return q6(w, p) * 16 + 15;
        endcase
    endfunction

    function automatic int exp_win(input int pat, input int r, input int c);
        int w, m;
        w = (r / 2) * (I_SIZE / 2) + (c / 2);
        case (pat)
            0: return 100;
            1: return 0;
            2: return 255;
            3: return 20;
            4: return 77;
            5: return 9;
            default: begin
                m = 0;
                for (int p = 0; p < 4; p++) if (q6(w, p) > m) m = q6(w, p);
                return m;
            end
        endcase
    endfunction

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    task automatic run_frame(input int pat, input bit gaps, input int npix, input bit push);
        int r, c, raw;
        for (int idx = 0; idx < npix; idx++) begin
            r = idx / I_SIZE;
            c = idx % I_SIZE;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                end
            end
            @(negedge clk);
            raw = raw_val(pat, r, c);
            i_data = raw[I_BW-1:0];
            i_valid = 1'b1;
            if (push && (r % 2 == 1) && (c % 2 == 1)) begin
                exp_q.push_back(O_BW'(exp_win(pat, r, c)));
                exp_t_q.push_back(cyc + 2);
                last_out_t = cyc + 2;
            end
        end
    endtask

    task automatic do_clear(input int which, input bit with_pix);
        @(negedge clk);
        case (which)
            0: rst = 1'b1;
            1: self_rst = 1'b1;
            default: user_reset = 1'b1;
        endcase
        i_valid = with_pix;
        i_data = 20'd4000;
        @(negedge clk);
        rst = 1'b0;
        self_rst = 1'b0;
        user_reset = 1'b0;
        i_valid = 1'b0;
        end_seen = 1'b0;
        check_val("clr_o_end", o_end, 0);
        check_val("clr_o_valid", o_valid, 0);
    endtask

    // scoreboard
    task automatic settle_and_compare(input string tag, input bit full);
        int n;
        idle(6);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_val%0d", tag, i), got_q[i], exp_q[i]);
            check_val($sformatf("%s_t%0d", tag, i), got_t_q[i], exp_t_q[i]);
        end
        if (full) begin
            check_val({tag, "_end_seen"}, end_seen, 1);
            check_val({tag, "_end_cyc"}, end_cyc, last_out_t + 1);
        end
        exp_q.delete();
        exp_t_q.delete();
        got_q.delete();
        got_t_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        global_rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_o_valid", o_valid, 0);
        check_val("rst_o_data", o_data, 0);
        check_val("rst_o_end", o_end, 0);

        // constant frame, then extra pixels after o_end must be ignored
        i_bias = '0;
        run_frame(0, 1'b0, NPIX, 1'b1);
        idle(3);
        run_frame(0, 1'b0, 30, 1'b0);
        settle_and_compare("const", 1'b1);
        check_val("end_hold", o_end, 1);
        do_clear(0, 1'b0);

        // ReLU clamp, saturation and bias offset
        i_bias = 16'd20;
        run_frame(1, 1'b0, NPIX, 1'b1);
        settle_and_compare("relu", 1'b1);
        do_clear(1, 1'b0);
        i_bias = '0;
        run_frame(2, 1'b0, NPIX, 1'b1);
        settle_and_compare("sat", 1'b1);
        do_clear(1, 1'b0);
        i_bias = 16'd420;
        run_frame(3, 1'b0, NPIX, 1'b1);
        settle_and_compare("bias", 1'b1);
        do_clear(0, 1'b0);

        // window position coverage
        i_bias = '0;
        run_frame(4, 1'b0, NPIX, 1'b1);
        settle_and_compare("rot", 1'b1);
        do_clear(0, 1'b0);
        run_frame(6, 1'b0, NPIX, 1'b1);
        settle_and_compare("mix", 1'b1);
        do_clear(0, 1'b0);

        // gapped valid
        run_frame(0, 1'b1, NPIX, 1'b1);
        idle(1);
        settle_and_compare("gaps", 1'b1);
        do_clear(1, 1'b0);

        // mid-frame software clear colliding with a valid pixel
        run_frame(0, 1'b0, 300, 1'b1);
        do_clear(2, 1'b1);
        check_val("uclr_no_end", end_seen, 0);
        run_frame(5, 1'b0, NPIX, 1'b1);
        settle_and_compare("uclr", 1'b1);
        do_clear(0, 1'b0);

        // asynchronous reset while an output is being presented
        run_frame(0, 1'b0, 26, 1'b1);
        idle(1);
        @(negedge clk);
        check_val("pre_arst_valid", o_valid, 1);
        #2;
        global_rst_n = 1'b0;
        #1;
        check_val("arst_o_valid", o_valid, 0);
        check_val("arst_o_data", o_data, 0);
        check_val("arst_o_end", o_end, 0);
        @(negedge clk);
        global_rst_n = 1'b1;
        end_seen = 1'b0;
        settle_and_compare("arst", 1'b0);
        check_val("arst_end_after", end_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
